// File: rtl/uart_word_pkg.sv
// Shared definitions for the UART word sequencer: RX/TX state encodings,
// parameter defaults and a small sizing helper.
package uart_word_pkg;

   localparam int unsigned WORD_BYTES_DEFAULT     = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1_000_000;

   // RX path: wait for a byte, settle for one cycle, present the word.
   typedef enum logic [1:0] {
      RX_COLLECT,
      RX_GUARD,
      RX_HOLD
   } rx_state_t;

   // TX path: one LOAD/START/GUARD/WAIT round per byte.
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_LOAD,
      TX_START,
      TX_GUARD,
      TX_WAIT
   } tx_state_t;

   // Width of a byte-slot index for a word of the given size.
   function automatic int unsigned idx_width(input int unsigned bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// TX half of the UART word sequencer: accepts a word on a valid/ready
// handshake and feeds it to the UART one byte at a time, MSB byte first.
module uart_word_serializer
   import uart_word_pkg::*;
#(
   parameter int unsigned WORD_BYTES = WORD_BYTES_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [8*WORD_BYTES-1:0] word_in,
   input  logic                    word_in_valid,
   output logic                    word_in_ready,
   input  logic                    tx_busy,
   output logic                    tx_start,
   output logic [7:0]              tx_data
);

   localparam int unsigned      IDX_W    = idx_width(WORD_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

   tx_state_t               state;
   logic [IDX_W-1:0]        idx;
   logic [8*WORD_BYTES-1:0] shreg;

   // Byte sequencing; the shift register advances only once the UART has
   // finished a byte, so tx_data holds steady for the whole transmission.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, so state, index and data never race each other.
      if (rst) begin
         state <= TX_IDLE;
         idx   <= '0;
         // NOTE: the data register is reset as well because tx_data is
         // driven straight from it and must not show stale bytes.
         shreg <= '0;
      end else begin
         unique case (state)
            TX_IDLE: begin
               if (word_in_valid) begin
                  shreg <= word_in;
                  idx   <= '0;
                  state <= TX_LOAD;
               end
            end
            TX_LOAD: begin
               if (!tx_busy) state <= TX_START;
            end
            TX_START: state <= TX_GUARD;
            // tx_busy only rises the cycle after tx_start, so it is not
            // trusted until WAIT.
            TX_GUARD: state <= TX_WAIT;
            TX_WAIT: begin
               if (!tx_busy) begin
                  if (idx == LAST_IDX) begin
                     state <= TX_IDLE;
                  end else begin
                     idx   <= idx + 1'b1;
                     shreg <= {shreg[8*WORD_BYTES-9:0], 8'h00};
                     state <= TX_LOAD;
                  end
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

   // Outputs decode registered state; rst masks them during reset cycles.
   assign tx_data       = shreg[8*WORD_BYTES-1 -: 8];
   assign tx_start      = (state == TX_START) && !rst;
   assign word_in_ready = (state == TX_IDLE) && !rst;

endmodule

// File: rtl/uart_word_sequencer.sv
// UART word sequencer: assembles received bytes into words (MSB byte first)
// with an idle timeout for partial words, and serializes outgoing words
// through uart_word_serializer. RX and TX run independently.
module uart_word_sequencer
   import uart_word_pkg::*;
#(
   parameter int unsigned WORD_BYTES     = WORD_BYTES_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_readable,
   input  logic [7:0]              rx_data,
   output logic                    rx_used_tick,
   input  logic                    tx_busy,
   output logic                    tx_start,
   output logic [7:0]              tx_data,
   output logic [8*WORD_BYTES-1:0] word_out,
   output logic                    word_out_valid,
   input  logic                    word_out_ready,
   input  logic [8*WORD_BYTES-1:0] word_in,
   input  logic                    word_in_valid,
   output logic                    word_in_ready,
   output logic                    timeout_err
);

   localparam int unsigned      IDX_W       = idx_width(WORD_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORD_BYTES - 1);
   localparam int unsigned      CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned      TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TO_LAST_INT);
   localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

   rx_state_t               rx_state;
   logic [IDX_W-1:0]        rx_idx;
   logic [CNT_W-1:0]        idle_cnt;
   logic [8*WORD_BYTES-1:0] rx_word;
   logic                    timeout_q;

   // RX assembly. Bytes shift in from the LSB end, so after a full word the
   // first byte sits in the top slot; a discarded partial word is pushed out
   // by the next complete one.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state  <= RX_COLLECT;
         rx_idx    <= '0;
         idle_cnt  <= '0;
         rx_word   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         unique case (rx_state)
            RX_COLLECT: begin
               if (rx_readable) begin
                  rx_word  <= {rx_word[8*WORD_BYTES-9:0], rx_data};
                  idle_cnt <= '0;
                  rx_state <= RX_GUARD;
               end else if (TIMEOUT_EN && (rx_idx != '0)) begin
                  if (idle_cnt == TO_LAST) begin
                     rx_idx    <= '0;
                     idle_cnt  <= '0;
                     timeout_q <= 1'b1;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
            end
            // The UART drops its flag on the consuming edge; this cycle gives
            // the cleared flag time to settle before COLLECT looks again.
            RX_GUARD: begin
               if (rx_idx == LAST_IDX) begin
                  rx_state <= RX_HOLD;
               end else begin
                  rx_idx   <= rx_idx + 1'b1;
                  rx_state <= RX_COLLECT;
               end
            end
            RX_HOLD: begin
               if (word_out_ready) begin
                  rx_idx   <= '0;
                  rx_state <= RX_COLLECT;
               end
            end
            default: rx_state <= RX_COLLECT;
         endcase
      end
   end

   // The tick is raised in the same cycle the byte is taken so the UART
   // clears its flag at that edge; this puts word_out_valid two cycles
   // after the tick of the last byte.
   assign rx_used_tick   = (rx_state == RX_COLLECT) && rx_readable && !rst;
   assign word_out       = rx_word;
   assign word_out_valid = (rx_state == RX_HOLD) && !rst;
   assign timeout_err    = timeout_q && !rst;

   uart_word_serializer #(
      .WORD_BYTES (WORD_BYTES)
   ) u_serializer (
      .clk           (clk),
      .rst           (rst),
      .word_in       (word_in),
      .word_in_valid (word_in_valid),
      .word_in_ready (word_in_ready),
      .tx_busy       (tx_busy),
      .tx_start      (tx_start),
      .tx_data       (tx_data)
   );

endmodule

// File: doc/uart_word_sequencer.md
UART_WORD_SEQUENCER -- requirements
Module: uart_word_sequencer

Interface
REQ-001 Parameter WORD_BYTES, default 4: bytes per word; legal range 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: idle clk cycles before a partial RX word is discarded; 0 disables the timeout.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_readable  in  1  UART RX buffer holds an unread byte.
REQ-006 rx_data  in  8  UART RX buffered byte.
REQ-007 rx_used_tick  out  1  one-cycle pulse: byte consumed, clear RX flag.
REQ-008 tx_busy  in  1  UART TX in progress; rises one cycle after tx_start.
REQ-009 tx_start  out  1  one-cycle pulse launching transmission of tx_data.
REQ-010 tx_data  out  8  byte to transmit; stable from tx_start until tx_busy falls.
REQ-011 word_out  out  8*WORD_BYTES  assembled RX word.
REQ-012 word_out_valid  out  1  word_out holds a complete word.
REQ-013 word_out_ready  in  1  consumer accepts word_out.
REQ-014 word_in  in  8*WORD_BYTES  word to transmit.
REQ-015 word_in_valid  in  1  producer offers word_in.
REQ-016 word_in_ready  out  1  sequencer can accept word_in.
REQ-017 timeout_err  out  1  one-cycle pulse on partial-word discard.

Function
REQ-018 RX and TX paths SHALL operate independently and concurrently.
REQ-019 RX FSM states: COLLECT, GUARD, HOLD.
REQ-020 COLLECT with rx_readable=1: latch rx_data into byte slot, pulse rx_used_tick, go to GUARD.
REQ-021 GUARD lasts exactly one cycle, with rx_readable ignored; exit to HOLD if the slot just filled was byte WORD_BYTES-1, else COLLECT.
REQ-022 Byte order: first received byte lands in word_out[8*WORD_BYTES-1 -: 8] (MSB first).
REQ-023 HOLD: word_out_valid=1, word_out stable; on word_out_ready=1, clear valid, reset byte index to 0, go to COLLECT the next cycle.
REQ-024 In HOLD, incoming bytes SHALL remain unconsumed (no rx_used_tick) and be left in the UART buffer.
REQ-025 Timeout counter runs only in COLLECT with byte index>0 and resets on each consumed byte; on reaching TIMEOUT_CYCLES: index to 0, pulse timeout_err, word_out_valid stays 0.
REQ-026 Latency: word_out_valid SHALL rise 2 cycles after the rx_used_tick pulse of the last byte.
REQ-027 TX FSM states: IDLE, LOAD, START, GUARD, WAIT.
REQ-028 IDLE: word_in_ready=1; on word_in_valid=1, capture word_in into shift register, index 0, go to LOAD.
REQ-029 LOAD: drive tx_data with byte[index] (MSB first); go to START when tx_busy=0, else stay.
REQ-030 START: pulse tx_start for exactly one cycle; go to GUARD.
REQ-031 GUARD: one cycle, with tx_busy ignored; go to WAIT.
REQ-032 WAIT: on tx_busy=0, if index=WORD_BYTES-1 go to IDLE, else increment index and go to LOAD.
REQ-033 word_in_ready SHALL be 0 in every TX state except IDLE; word_in is sampled only on the IDLE handshake.
REQ-034 rx_used_tick and tx_start SHALL never be high for two consecutive cycles.
REQ-035 If word_out_ready is already high on the first cycle of HOLD, the handshake completes that cycle: valid is high for exactly one cycle.

Reset
REQ-036 On rst=1: both FSMs go to COLLECT/IDLE; indices, timeout counter and shift registers clear to 0.
REQ-037 On rst=1: word_out_valid, rx_used_tick, tx_start and timeout_err are 0, and word_in_ready is 0.
REQ-038 word_in_ready SHALL rise in the first cycle after rst deasserts.
REQ-039 Reset mid-word SHALL discard the partial RX/TX word without any further tick or start pulse.

Structure
REQ-040 Package uart_word_pkg SHALL hold the RX/TX state encodings and the WORD_BYTES and TIMEOUT_CYCLES defaults.
REQ-041 The TX path SHALL be a sub-module uart_word_serializer (REQ-027..033); the RX path stays in the top level.

Verification
REQ-042 Feed bytes 0xDE,0xAD,0xBE,0xEF with word_out_ready=1 -> word_out=0xDEADBEEF valid one cycle; four rx_used_tick pulses, none back-to-back.
REQ-043 Offer word_in=0x01020304 while the TX model asserts busy 10 cycles per byte -> tx_data sequence 01,02,03,04; four tx_start pulses, each issued only after busy is low; word_in_ready returns high afterwards.
REQ-044 Feed 2 bytes with TIMEOUT_CYCLES=100, then idle -> timeout_err pulse at cycle 100; next 4 bytes form a clean word.
REQ-045 Hold word_out_ready=0 while a 5th byte arrives -> no rx_used_tick until the ready handshake; the byte becomes MSB of the next word.
REQ-046 Assert rst mid-TX after byte 2 -> no further tx_start, word_in_ready=1 one cycle after release.
REQ-047 Run RX and TX concurrently with 8 random words each -> all words match end to end, with no dropped or duplicated bytes.
